// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared fetch-unit types, widths and reset PC
package npc_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } ifu_state_e;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifu_if.sv
// rtl/ifu_if.sv - fetch unit bundle: imem request/response, decode output, redirect
interface ifu_if;
    import npc_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            out_err;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output out_valid, out_pc, out_inst, out_err,
        input  out_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  out_valid, out_pc, out_inst, out_err,
        output out_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ifu_pc_reg.sv
// rtl/ifu_pc_reg.sv - fetch PC register with redirect load and +4 advance
module pc_reg
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect wins over the sequential advance; the add wraps naturally.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = align_pc(load_pc_i);
        end else if (inc_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= align_pc(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - single-outstanding instruction fetch unit with redirect and fault halt
module ifu
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    ifu_if.master  bus
);

    ifu_state_e      state_q;
    logic            kill_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [31:0]     out_inst_q;
    logic            out_err_q;

    logic [XLEN-1:0] pc;
    logic            handshake;
    logic            pc_inc;

    assign handshake = out_valid_q & bus.out_ready;
    assign pc_inc    = (state_q == ST_HOLD) & handshake & ~out_err_q;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (bus.redirect_valid),
        .load_pc_i (bus.redirect_pc),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_REQ;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    // A redirect alongside acceptance still owes us one response to drain.
                    if (bus.imem_req_ready) begin
                        state_q <= ST_WAIT;
                        kill_q  <= bus.redirect_valid;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        kill_q <= 1'b0;
                        if (kill_q || bus.redirect_valid) begin
                            state_q <= ST_REQ;
                        end else begin
                            state_q     <= ST_HOLD;
                            out_valid_q <= 1'b1;
                            out_pc_q    <= pc;
                            out_inst_q  <= bus.imem_rsp_data;
                            out_err_q   <= bus.imem_rsp_err;
                        end
                    end else if (bus.redirect_valid) begin
                        kill_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.redirect_valid) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_REQ;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= out_err_q ? ST_HALT : ST_REQ;
                    end
                end
                ST_HALT: begin
                    if (bus.redirect_valid) begin
                        out_err_q <= 1'b0;
                        state_q   <= ST_REQ;
                    end
                end
                default: begin
                    state_q <= ST_REQ;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = rst & (state_q == ST_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_inst       = out_inst_q;
    assign bus.out_err        = out_err_q;

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - self-checking bench for ifu against a flag-level fetch model
module tb_ifu;
    import npc_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifu_if bus();

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: what the fetch unit owes the world, as plain flags.
    logic [31:0] m_pc;
    bit          m_inflight, m_drop, m_have, m_halted;
    logic [31:0] m_opc, m_oinst;
    bit          m_oerr;

    // Memory and environment knobs.
    bit          k_ready, k_oready, k_rd, k_force_rsp, k_err_rand;
    logic [31:0] k_rdpc, k_err_addr;
    int          k_dmin, k_dmax;

    bit          mem_pend;
    int          mem_wait;
    logic [31:0] mem_addr;

    int          cyc;
    logic [31:0] hs_pc[$];
    int          hs_cyc[$];

    task automatic model_reset();
        m_pc = RST_PC; m_inflight = 0; m_drop = 0; m_have = 0; m_halted = 0;
        m_opc = '0; m_oinst = '0; m_oerr = 0;
    endtask

    task automatic cycle();
        bit          rv, re, exp_req, accepted;
        logic [31:0] rdata, tgt;
        rv    = k_force_rsp || (mem_pend && mem_wait == 0);
        rdata = $urandom;
        re    = !k_force_rsp && ((mem_addr == k_err_addr) || (k_err_rand && $urandom_range(0, 15) == 0));
        bus.imem_req_ready = k_ready;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rdata;
        bus.imem_rsp_err   = re;
        bus.out_ready      = k_oready;
        bus.redirect_valid = k_rd;
        bus.redirect_pc    = k_rdpc;
        #1;
        exp_req = rst && !m_inflight && !m_have && !m_halted;
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        if (exp_req) check_eq("req_addr", bus.imem_req_addr, m_pc);
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_have));
        check_eq("out_pc", bus.out_pc, m_opc);
        check_eq("out_inst", bus.out_inst, m_oinst);
        check_eq("out_err", 32'(bus.out_err), 32'(m_oerr));
        accepted = bus.imem_req_valid && k_ready;
        if (rst && m_have && k_oready && !k_rd) begin
            hs_pc.push_back(m_opc);
            hs_cyc.push_back(cyc);
        end
        if (!rst) begin
            model_reset();
        end else begin
            tgt = {k_rdpc[31:2], 2'b00};
            if (m_halted) begin
                if (k_rd) begin m_pc = tgt; m_halted = 0; m_oerr = 0; end
            end else if (m_have) begin
                if (k_rd) begin
                    m_have = 0; m_pc = tgt;
                end else if (k_oready) begin
                    m_have = 0;
                    if (m_oerr) m_halted = 1; else m_pc = m_pc + 32'd4;
                end
            end else if (m_inflight) begin
                if (rv) begin
                    m_inflight = 0;
                    if (!m_drop && !k_rd) begin
                        m_have = 1; m_opc = m_pc; m_oinst = rdata; m_oerr = re;
                    end
                    m_drop = 0;
                end else if (k_rd) begin
                    m_drop = 1;
                end
                if (k_rd) m_pc = tgt;
            end else begin
                if (k_ready) begin m_inflight = 1; m_drop = k_rd; end
                if (k_rd) m_pc = tgt;
            end
        end
        if (!rst) begin
            mem_pend = 0;
        end else begin
            if (rv) mem_pend = 0;
            else if (mem_pend) mem_wait--;
            if (accepted) begin
                mem_pend = 1;
                mem_wait = $urandom_range(k_dmin, k_dmax);
                mem_addr = bus.imem_req_addr;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic until_have(input string tag);
        int n = 0;
        while (!m_have && n < 20) begin cycle(); n++; end
        check_eq({tag, "_have_timeout"}, 32'(n < 20), 32'd1);
    endtask

    task automatic until_inflight(input string tag);
        int n = 0;
        while (!m_inflight && n < 20) begin cycle(); n++; end
        check_eq({tag, "_inflight_timeout"}, 32'(n < 20), 32'd1);
    endtask

    task automatic until_req(input string tag);
        int n = 0;
        while (!bus.imem_req_valid && n < 20) begin cycle(); n++; end
        check_eq({tag, "_req_timeout"}, 32'(n < 20), 32'd1);
    endtask

    task automatic until_hs(input string tag);
        int n = 0;
        while (hs_pc.size() == 0 && n < 30) begin cycle(); n++; end
        check_eq({tag, "_hs_timeout"}, 32'(n < 30), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved_pc, saved_inst;
        int          nreq;
        model_reset();
        k_ready = 1; k_oready = 1; k_rd = 0; k_rdpc = '0; k_force_rsp = 0;
        k_err_rand = 0; k_err_addr = 32'h0000_0001; k_dmin = 0; k_dmax = 0;
        mem_pend = 0; mem_wait = 0; mem_addr = '0; cyc = 0;

        rst = 0;
        @(negedge clk);
        repeat (3) cycle();
        rst = 1;

        // Back-to-back fetch with ideal memory and consumer.
        hs_pc.delete(); hs_cyc.delete();
        repeat (9) cycle();
        check_eq("seq_count", 32'(hs_pc.size()), 32'd3);
        if (hs_pc.size() == 3) begin
            check_eq("seq_pc0", hs_pc[0], 32'h8000_0000);
            check_eq("seq_pc1", hs_pc[1], 32'h8000_0004);
            check_eq("seq_pc2", hs_pc[2], 32'h8000_0008);
            check_eq("seq_gap", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
        end

        // Consumer stall in HOLD.
        k_oready = 0;
        until_have("stall");
        saved_pc = m_opc; saved_inst = m_oinst;
        nreq = 0;
        repeat (5) begin cycle(); if (bus.imem_req_valid) nreq++; end
        check_eq("stall_pc", bus.out_pc, saved_pc);
        check_eq("stall_inst", bus.out_inst, saved_inst);
        check_eq("stall_noreq", 32'(nreq), 32'd0);
        k_oready = 1;
        cycle();
        until_req("stall");
        check_eq("stall_next", bus.imem_req_addr, saved_pc + 32'd4);

        // Redirect while waiting drops the in-flight response.
        k_dmin = 2; k_dmax = 2;
        until_inflight("kill");
        cycle();
        k_rd = 1; k_rdpc = 32'h8000_0103;
        cycle();
        k_rd = 0; k_dmin = 0; k_dmax = 0;
        until_req("kill");
        check_eq("kill_addr", bus.imem_req_addr, 32'h8000_0100);
        hs_pc.delete(); hs_cyc.delete();
        until_hs("kill");
        if (hs_pc.size() > 0) check_eq("kill_outpc", hs_pc[0], 32'h8000_0100);

        // Redirect beats a same-cycle handshake.
        until_have("prio");
        hs_pc.delete(); hs_cyc.delete();
        k_rd = 1; k_rdpc = 32'h8000_0200;
        cycle();
        k_rd = 0;
        check_eq("prio_nohs", 32'(hs_pc.size()), 32'd0);
        until_req("prio");
        check_eq("prio_addr", bus.imem_req_addr, 32'h8000_0200);

        // Faulted fetch halts until redirect.
        k_err_addr = 32'h8000_0010;
        k_ready = 0; k_rd = 1; k_rdpc = 32'h8000_0010;
        cycle();
        k_rd = 0; k_ready = 1;
        until_have("err");
        check_eq("err_flag", 32'(bus.out_err), 32'd1);
        check_eq("err_pc", bus.out_pc, 32'h8000_0010);
        cycle();
        nreq = 0;
        repeat (6) begin cycle(); if (bus.imem_req_valid) nreq++; end
        check_eq("halt_noreq", 32'(nreq), 32'd0);
        k_rd = 1; k_rdpc = 32'h8000_0000;
        cycle();
        k_rd = 0; k_err_addr = 32'h0000_0001;
        check_eq("halt_errclr", 32'(bus.out_err), 32'd0);
        until_req("halt");
        check_eq("halt_addr", bus.imem_req_addr, 32'h8000_0000);

        // PC wraps past the top of the address space.
        until_inflight("wrap");
        until_req("wrap_pre");
        k_ready = 0; k_rd = 1; k_rdpc = 32'hFFFF_FFFE;
        cycle();
        k_rd = 0; k_ready = 1;
        check_eq("wrap_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        hs_pc.delete(); hs_cyc.delete();
        until_hs("wrap");
        until_req("wrap");
        check_eq("wrap_next", bus.imem_req_addr, 32'h0000_0000);

        // Reset in WAIT; the late response after release is ignored.
        k_dmin = 5; k_dmax = 5;
        until_inflight("rstw");
        rst = 0;
        cycle();
        rst = 1; k_force_rsp = 1; k_dmin = 3; k_dmax = 3;
        cycle();
        k_force_rsp = 0;
        check_eq("rstw_noout", 32'(bus.out_valid), 32'd0);
        hs_pc.delete(); hs_cyc.delete();
        until_hs("rstw");
        if (hs_pc.size() > 0) check_eq("rstw_pc", hs_pc[0], RST_PC);
        k_dmin = 0; k_dmax = 2;

        // Randomized traffic.
        k_err_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) != 0);
            k_ready  = ($urandom_range(0, 3) != 0);
            k_oready = ($urandom_range(0, 2) != 0);
            k_rd     = ($urandom_range(0, 9) == 0);
            k_rdpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
